branch_resolver: RTL

- Execute-side counterpart of the fetch-stage branch predictor in the 5-stage RV32I pipeline.
- Carries each fetch-time prediction (taken bit + predicted target) through the F/D and D/E pipeline registers alongside the instruction.
- Compares that prediction against the actual outcome in E, then drives redirect, FlushD and FlushE.
- Emits predictor training updates through a valid/ready queue, and keeps branch and mispredict statistics.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/branch_upd_fifo.sv | 80 ++++++++
 rtl/branch_resolver.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the execute-side branch logic.
package riscv_pkg;

  localparam int XLEN = 32;

  // Control-transfer opcodes decoded upstream into BranchE / JumpE.
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // One predictor training record: where the branch was, what it did.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } upd_t;

  localparam int UPD_W = 2 * XLEN + 1;

endpackage

// File: rtl/branch_upd_fifo.sv
// First-word-fall-through queue holding predictor training updates.
// A push into a full queue is refused (drop pulses) unless a pop happens
// in the same cycle; a push into an empty queue is not bypassed to the head.
module branch_upd_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         rd_ready,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_s, empty_s, pop_s, push_ok_s;

  // Occupancy flags and handshake qualification.
  always_comb begin
    full_s    = (cnt_q == (AW+1)'(DEPTH));
    empty_s   = (cnt_q == {(AW+1){1'b0}});
    pop_s     = rd_ready & ~empty_s;
    push_ok_s = push & (~full_s | pop_s);
    drop      = push & full_s & ~pop_s;
  end

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok_s) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset also scrubs storage so the head reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wptr_q <= {AW{1'b0}};
      rptr_q <= {AW{1'b0}};
      cnt_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_valid = ~empty_s;
  assign rd_data  = mem_q[rptr_q];

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: carries the fetch-time prediction down
// the pipe, detects mispredicts, drives recovery and emits training updates.
module branch_resolver
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int QDEPTH = 2,
  parameter int CNTW   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            FlushE_hz,
  input  logic [XLEN-1:0] PCF,
  input  logic            PredTakenF,
  input  logic [XLEN-1:0] PredTargetF,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            FlushD,
  output logic            FlushE,
  output logic            RedirectE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic            UpdValid,
  input  logic            UpdReady,
  output logic [XLEN-1:0] UpdPC,
  output logic            UpdTaken,
  output logic [XLEN-1:0] UpdTarget,
  output logic [CNTW-1:0] BranchCount,
  output logic [CNTW-1:0] MispredCount,
  output logic [CNTW-1:0] UpdDropCount
);

  localparam int W = 2 * XLEN + 1;

  logic            pred_taken_fd_q, pred_taken_fd_d;
  logic [XLEN-1:0] pred_target_fd_q, pred_target_fd_d;
  logic            pred_taken_de_q, pred_taken_de_d;
  logic [XLEN-1:0] pred_target_de_q, pred_target_de_d;
  logic [CNTW-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNTW-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

  logic            resolved_s, mispredict_s;
  logic [XLEN-1:0] redirect_pc_s;
  logic            flush_d_s, flush_e_s;
  logic            drop_s;
  logic [W-1:0]    upd_wdata_s, upd_rdata_s;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic en);
    if (en && (v != {CNTW{1'b1}})) begin
      return v + CNTW'(1);
    end else begin
      return v;
    end
  endfunction

  // Compare the carried prediction against the actual E-stage outcome.
  always_comb begin
    resolved_s    = BranchE | JumpE;
    mispredict_s  = 1'b0;
    redirect_pc_s = {XLEN{1'b0}};
    if (resolved_s) begin
      mispredict_s  = (PCSrcE != pred_taken_de_q) |
                      (PCSrcE & pred_taken_de_q & (pred_target_de_q != PCTargetE));
      redirect_pc_s = PCSrcE ? PCTargetE : (PCE + XLEN'(32'd4));
    end else begin
      mispredict_s  = 1'b0;
      redirect_pc_s = {XLEN{1'b0}};
    end
    flush_d_s = mispredict_s;
    flush_e_s = mispredict_s | FlushE_hz;
  end

  // Prediction pipeline: F/D flush beats stall; D/E clears on any E flush.
  always_comb begin
    pred_taken_fd_d  = pred_taken_fd_q;
    pred_target_fd_d = pred_target_fd_q;
    if (flush_d_s) begin
      pred_taken_fd_d  = 1'b0;
      pred_target_fd_d = {XLEN{1'b0}};
    end else if (StallD) begin
      pred_taken_fd_d  = pred_taken_fd_q;
      pred_target_fd_d = pred_target_fd_q;
    end else begin
      pred_taken_fd_d  = PredTakenF;
      pred_target_fd_d = PredTargetF;
    end
    if (flush_e_s) begin
      pred_taken_de_d  = 1'b0;
      pred_target_de_d = {XLEN{1'b0}};
    end else begin
      pred_taken_de_d  = pred_taken_fd_q;
      pred_target_de_d = pred_target_fd_q;
    end
  end

  // Saturating event counters.
  always_comb begin
    branch_cnt_d  = sat_inc(branch_cnt_q, resolved_s);
    mispred_cnt_d = sat_inc(mispred_cnt_q, mispredict_s);
    drop_cnt_d    = sat_inc(drop_cnt_q, drop_s);
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_taken_fd_q  <= 1'b0;
      pred_target_fd_q <= {XLEN{1'b0}};
      pred_taken_de_q  <= 1'b0;
      pred_target_de_q <= {XLEN{1'b0}};
      branch_cnt_q     <= {CNTW{1'b0}};
      mispred_cnt_q    <= {CNTW{1'b0}};
      drop_cnt_q       <= {CNTW{1'b0}};
    end else begin
      pred_taken_fd_q  <= pred_taken_fd_d;
      pred_target_fd_q <= pred_target_fd_d;
      pred_taken_de_q  <= pred_taken_de_d;
      pred_target_de_q <= pred_target_de_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
      drop_cnt_q       <= drop_cnt_d;
    end
  end

  // Training record layout matches riscv_pkg::upd_t: {pc, taken, target}.
  assign upd_wdata_s = {PCE, PCSrcE, PCTargetE};

  branch_upd_fifo #(
    .DEPTH (QDEPTH),
    .W     (W)
  ) u_upd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (resolved_s),
    .wdata    (upd_wdata_s),
    .rd_ready (UpdReady),
    .rd_valid (UpdValid),
    .rd_data  (upd_rdata_s),
    .drop     (drop_s)
  );

  assign UpdPC        = upd_rdata_s[W-1 -: XLEN];
  assign UpdTaken     = upd_rdata_s[XLEN];
  assign UpdTarget    = upd_rdata_s[XLEN-1:0];
  assign FlushD       = flush_d_s;
  assign FlushE       = flush_e_s;
  assign RedirectE    = mispredict_s;
  assign RedirectPCE  = redirect_pc_s;
  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;
  assign UpdDropCount = drop_cnt_q;

endmodule
